regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Writeback arbiter that owns the single write port of the 32×32 integer register file. It merges single-cycle ALU results with buffered long-latency (load / mul-div) results and drives the register file's `we`, `rd_addr` and `rd_din` inputs. It also maintains a pending-destination scoreboard that the hazard unit reads to stall dependent issue.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `DEPTH`, 4, long-latency result FIFO entries; power of two, ≥2.
- `STARVE_LIMIT`, 8, consecutive ALU-owned cycles with a non-empty FIFO before forced drain.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result present this cycle; no backpressure.
- `alu_rd`  in  5  ALU destination.
- `alu_data`  in  XLEN  ALU result.
- `alu_stall`  out  1  request for upstream to hold `alu_valid` low next cycle.
- `lsu_valid`  in  1  long-latency result offered.
- `lsu_ready`  out  1  FIFO accepts; transfer when `lsu_valid & lsu_ready`.
- `lsu_rd`  in  5  long-latency destination.
- `lsu_data`  in  XLEN  long-latency result.
- `issue_valid`  in  1  long-latency op issued; mark `issue_rd` pending.
- `issue_rd`  in  5  destination of issued op.
- `rf_we`  out  1  register file write enable.
- `rf_rd_addr`  out  5  register file write address.
- `rf_rd_din`  out  XLEN  register file write data.
- `pending`  out  32  scoreboard; bit n = xn awaiting long-latency result.

## Operation
- FIFO: pushes on an `lsu` handshake. `lsu_ready = (count != DEPTH)`, computed from registered count. A pop in the same cycle does not make a full FIFO accept.
- Port arbitration, each cycle:
  - if `alu_valid & alu_rd != 0`, the ALU wins, unless `alu_stall` is registered high and `alu_valid = 0`;
  - otherwise the FIFO head is popped if non-empty;
  - otherwise idle.
- ALU results are never dropped or delayed. `alu_valid` while `alu_stall = 1` is still written, and the FIFO waits.
- `alu_valid` with `alu_rd = 0` does not use the port, so the FIFO may drain that cycle.
- FIFO entries with rd = 0 are popped with `rf_we = 0`.
- Starvation counter:
  - increments when the ALU owns the port and the FIFO is non-empty;
  - clears on any FIFO pop or when the FIFO is empty;
  - saturates at `STARVE_LIMIT`.
  - `alu_stall` (registered) = counter == `STARVE_LIMIT`. It deasserts the cycle after the pop.
- Scoreboard:
  - `issue_valid & issue_rd != 0` sets `pending[issue_rd]`.
  - A FIFO pop writing rd clears `pending[rd]`.
  - Simultaneous set and clear of the same bit: set wins.
  - ALU writes never touch `pending`. WAW ordering is the hazard unit's job.
  - `pending[0]` is constantly 0.
- Write ordering: FIFO entries are written in arrival order.

## Timing
- Reset (async assert, sync-safe deassert): `rf_we = 0`, `rf_rd_addr = 0`, `rf_rd_din = 0`, `pending = 0`, `alu_stall = 0`, FIFO empty, `lsu_ready = 1`, counter 0.
- `rf_we`, `rf_rd_addr` and `rf_rd_din` are registered:
  - ALU result at cycle N appears on the port at N+1.
  - A FIFO pop at cycle N appears at N+1.
- Minimum `lsu` handshake to `rf_we` latency: 2 cycles (push at N, pop at N+1, write visible at N+2).
- `pending` clears in the same edge that registers `rf_we` for that entry, so the bit drops when the write is presented. Register-file contents update one further edge later; the hazard unit accounts for this.
- Reset mid-operation:
  - FIFO contents are discarded and `pending` is cleared.
  - No write is presented after reset.
  - `lsu_ready` returns to 1 immediately.

## Structure
- `defines.vh` holds `XLEN`, `REG_ADDR_W = 5`, `REG_COUNT = 32` and `X0_ADDR = 5'h00`.
- Sub-module `wb_fifo`: synchronous DEPTH-entry FIFO with {rd, data} payload, wrap-around read/write pointers, count, full and empty. Same `clk`/`rst` convention.
- Arbitration, starvation counter and scoreboard live in the top level.

## Test plan
- Reset: assert `rst = 0` mid-stream with 3 FIFO entries and `pending = 0x0000_0C00` → all outputs 0, `lsu_ready = 1`, and no `rf_we` after release.
- ALU path: `alu_valid`, rd = 5, data = 0xDEADBEEF at N → `rf_we = 1`, addr 5, din 0xDEADBEEF at N+1. With rd = 0 → `rf_we` stays 0.
- Backpressure: 4 `lsu` pushes while `alu_valid` is continuous → `lsu_ready = 0` after the 4th push. A 5th offer is held, not lost, and accepted after the first pop.
- Starvation: FIFO holds rd = 7; `alu_valid` (rd ≠ 0) continuously → `alu_stall = 1` after 8 ALU-owned cycles. Drop `alu_valid` → rd 7 written next cycle and `alu_stall` clears.
- Scoreboard: issue rd = 10, then a FIFO pop of rd = 10 in the same cycle as a new issue of rd = 10 → `pending[10]` stays 1.
- Ordering and x0: push (3, A), (0, B), (3, C) → writes: addr 3 = A, no write for B, then addr 3 = C. `pending[3]` ends at 0.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared constants for the register-file writeback slice.
// Holds register-file geometry and a small helper used by the arbiter
// and the long-latency result FIFO.
package regfile_writeback_pkg;

  localparam int              XLEN_DEF   = 32;
  localparam int              REG_ADDR_W = 5;
  localparam int              REG_COUNT  = 32;
  localparam logic [4:0]      X0_ADDR    = 5'h00;

  // x0 is hardwired zero: writes to it are discarded and it is never pending.
  function automatic logic is_x0(input logic [REG_ADDR_W-1:0] a);
    return a == X0_ADDR;
  endfunction

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: synchronous DEPTH-entry FIFO buffering long-latency results
// ({rd, data} payload) until the register-file write port is free.
// Ports:
//   clk, rst      clock, async active-low reset (empties the FIFO)
//   i_push        enqueue i_rd/i_data (ignored when full)
//   i_pop         dequeue head (ignored when empty)
//   o_rd, o_data  head entry
//   o_full        DEPTH entries held (from registered count)
//   o_empty       no entries held (from registered count)
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [REG_ADDR_W-1:0] i_rd,
  input  logic [XLEN-1:0]       i_data,
  output logic [REG_ADDR_W-1:0] o_rd,
  output logic [XLEN-1:0]       o_data,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);

  logic [REG_ADDR_W-1:0] r_mem_rd   [DEPTH];
  logic [XLEN-1:0]       r_mem_data [DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [PW:0]           r_count;
  logic                  w_push, w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rd    = r_mem_rd[r_rptr];
  assign o_data  = r_mem_data[r_rptr];

  // Payload storage needs no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_wptr]   <= i_rd;
      r_mem_data[r_wptr] <= i_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// regfile_writeback: owns the single write port of the 32x32 integer
// register file. ALU results always win the port; buffered long-latency
// results drain in arrival order when the port is free. A starvation
// counter asks upstream to bubble the ALU so the FIFO can drain, and a
// pending-destination scoreboard feeds the hazard unit.
// Ports:
//   clk, rst                          clock, async active-low reset
//   alu_valid/alu_rd/alu_data         single-cycle result, no backpressure
//   alu_stall                         ask upstream to hold alu_valid low
//   lsu_valid/lsu_ready/lsu_rd/lsu_data  long-latency result handshake
//   issue_valid/issue_rd              mark destination pending on issue
//   rf_we/rf_rd_addr/rf_rd_din        registered register-file write port
//   pending                           scoreboard, bit n = xn awaiting result
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_stall,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd_addr,
  output logic [XLEN-1:0]       rf_rd_din,
  output logic [REG_COUNT-1:0]  pending
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic                  r_we;
  logic [REG_ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]       r_din;
  logic [REG_COUNT-1:0]  r_pending;
  logic [CW-1:0]         r_starve;

  logic                  w_alu_win, w_pop, w_push;
  logic                  w_full, w_empty;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;
  logic [REG_COUNT-1:0]  w_pend_nxt;

  // ALU results are never dropped: a valid non-x0 ALU result owns the port
  // even while alu_stall is up (upstream may not have honoured it yet).
  assign w_alu_win = alu_valid && !is_x0(alu_rd);
  assign w_pop     = !w_alu_win && !w_empty;
  // Ready comes from the registered count only, so a same-cycle pop never
  // opens a full FIFO.
  assign lsu_ready = !w_full;
  assign w_push    = lsu_valid && lsu_ready;

  wb_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_rd    (lsu_rd),
    .i_data  (lsu_data),
    .o_rd    (w_head_rd),
    .o_data  (w_head_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Scoreboard: clear on the pop that presents the write, then apply the
  // issue set so a same-cycle reissue of that register stays pending.
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_pop && !is_x0(w_head_rd))
      w_pend_nxt[w_head_rd] = 1'b0;
    if (issue_valid && !is_x0(issue_rd))
      w_pend_nxt[issue_rd] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_pending <= '0;
      r_starve  <= '0;
    end else begin
      r_pending <= w_pend_nxt;

      if (w_alu_win) begin
        r_we   <= 1'b1;
        r_addr <= alu_rd;
        r_din  <= alu_data;
      end else if (w_pop) begin
        // x0 entries still leave the FIFO but never assert the write.
        r_we   <= !is_x0(w_head_rd);
        r_addr <= w_head_rd;
        r_din  <= w_head_data;
      end else begin
        r_we   <= 1'b0;
      end

      // Counts ALU-owned cycles that left a non-empty FIFO waiting.
      if (w_pop || w_empty)
        r_starve <= '0;
      else if (w_alu_win && r_starve != LIMIT)
        r_starve <= r_starve + CW'(1);
    end
  end

  assign alu_stall  = (r_starve == LIMIT);
  assign rf_we      = r_we;
  assign rf_rd_addr = r_addr;
  assign rf_rd_din  = r_din;
  assign pending    = r_pending;

endmodule

// File: tb/tb_regfile_writeback.sv
module tb_regfile_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, issue_valid;
  logic [4:0]  alu_rd, lsu_rd, issue_rd;
  logic [31:0] alu_data, lsu_data;
  logic        alu_stall, lsu_ready, rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_din, pending;

  int n_cmp = 0;
  int n_err = 0;

  logic [36:0] alu_q[$];
  logic [36:0] lsu_q[$];
  logic        prev_alu = 1'b0;

  regfile_writeback #(.XLEN(32), .DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_din(rf_rd_din), .pending(pending)
  );

  always #5 clk = ~clk;

  // Scoreboard producer: record what was driven at each active edge.
  always @(posedge clk) begin
    if (rst) begin
      prev_alu = alu_valid && (alu_rd != 5'd0);
      if (prev_alu) alu_q.push_back({alu_rd, alu_data});
      if (lsu_valid && lsu_ready && lsu_rd != 5'd0) lsu_q.push_back({lsu_rd, lsu_data});
    end else begin
      prev_alu = 1'b0;
    end
  end

  // Scoreboard consumer: every presented write must match the next expected one.
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst) begin
      if (rf_we) begin
        n_cmp++;
        if (prev_alu ? (alu_q.size() == 0) : (lsu_q.size() == 0)) begin
          n_err++;
          $display("FAIL wr_unexpected: got addr=%0d din=%h, nothing expected", rf_rd_addr, rf_rd_din);
        end else begin
          e = prev_alu ? alu_q.pop_front() : lsu_q.pop_front();
          if ({rf_rd_addr, rf_rd_din} !== e) begin
            n_err++;
            $display("FAIL wr_data: got addr=%0d din=%h, want addr=%0d din=%h",
                     rf_rd_addr, rf_rd_din, e[36:32], e[31:0]);
          end
        end
      end else if (prev_alu) begin
        n_cmp++; n_err++;
        $display("FAIL wr_missing_alu: rf_we=0, want ALU write");
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    logic [71:0] got;
    rst = 0; alu_valid = 0; lsu_valid = 0; issue_valid = 0;
    alu_rd = 0; lsu_rd = 0; issue_rd = 0; alu_data = 0; lsu_data = 0;
    repeat (2) tick();
    got = {rf_we, rf_rd_addr, rf_rd_din, pending, alu_stall, lsu_ready};
    n_cmp++;
    if (got !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_init: got %h want %h", got, {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1});
    end
    rst = 1; tick();
    // Build 3 FIFO entries and pending = x10,x11 while the ALU holds the port.
    issue_valid = 1; issue_rd = 10; tick();
    issue_rd = 11; tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h1111_0000;
    lsu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      lsu_rd = 5'(10 + i); lsu_data = 32'hA000_0000 + i; tick();
    end
    lsu_valid = 0; tick();
    n_cmp++;
    if (pending !== 32'h0000_0C00) begin
      n_err++; $display("FAIL reset_pre_pending: got %h want 00000c00", pending);
    end
    rst = 0; alu_valid = 0; #1;
    alu_q.delete(); lsu_q.delete();
    got = {rf_we, rf_rd_addr, rf_rd_din, pending, alu_stall, lsu_ready};
    n_cmp++;
    if (got !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_mid: got %h want %h", got, {1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1});
    end
    repeat (2) tick();
    rst = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (rf_we !== 1'b0 || pending !== 32'd0) begin
        n_err++; $display("FAIL reset_after: cyc %0d rf_we=%b pending=%h want 0/0", i, rf_we, pending);
      end
    end
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEAD_BEEF; tick();
    n_cmp++;
    if ({rf_we, rf_rd_addr, rf_rd_din} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
      n_err++; $display("FAIL alu_write: got we=%b addr=%0d din=%h want 1/5/deadbeef", rf_we, rf_rd_addr, rf_rd_din);
    end
    alu_rd = 0; alu_data = 32'h0000_0123; tick();
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL alu_x0: got rf_we=%b want 0", rf_we);
    end
    for (int i = 0; i < 6; i++) begin
      alu_rd = 5'($urandom_range(1, 31)); alu_data = $urandom; tick();
    end
    idle(2);
  endtask

  task automatic test_backpressure();
    alu_valid = 1;
    lsu_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = 5'(i + 1); alu_data = 32'hC000_0000 + i;
      lsu_rd = 5'(20 + i); lsu_data = 32'hB000_0000 + i; tick();
    end
    n_cmp++;
    if (lsu_ready !== 1'b0) begin
      n_err++; $display("FAIL bp_full: got lsu_ready=%b want 0", lsu_ready);
    end
    lsu_rd = 24; lsu_data = 32'hB000_0004;
    for (int i = 0; i < 2; i++) begin
      alu_rd = 5'(9 + i); alu_data = 32'hC100_0000 + i; tick();
      n_cmp++;
      if (lsu_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold: cyc %0d got lsu_ready=%b want 0", i, lsu_ready);
      end
    end
    alu_valid = 0; tick();
    n_cmp++;
    if (lsu_ready !== 1'b1) begin
      n_err++; $display("FAIL bp_reopen: got lsu_ready=%b want 1", lsu_ready);
    end
    tick();
    lsu_valid = 0;
    idle(8);
    n_cmp++;
    if (lsu_q.size() != 0 || alu_q.size() != 0) begin
      n_err++; $display("FAIL bp_drain: got %0d/%0d left want 0/0", lsu_q.size(), alu_q.size());
    end
  endtask

  task automatic test_starvation();
    issue_valid = 1; issue_rd = 7; tick();
    issue_valid = 0;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h5000_0000;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h7777_7777; tick();
    lsu_valid = 0;
    for (int k = 1; k <= 8; k++) begin
      alu_rd = 5'(1 + k); alu_data = 32'h5000_0000 + k; tick();
      n_cmp++;
      if (alu_stall !== (k == 8)) begin
        n_err++; $display("FAIL starve_cnt: cyc %0d got alu_stall=%b want %b", k, alu_stall, (k == 8));
      end
    end
    // ALU still valid while stalled: it is written and the FIFO keeps waiting.
    alu_rd = 12; alu_data = 32'h5000_00FF; tick();
    n_cmp++;
    if (alu_stall !== 1'b1 || pending[7] !== 1'b1) begin
      n_err++; $display("FAIL starve_sat: got stall=%b pend7=%b want 1/1", alu_stall, pending[7]);
    end
    alu_valid = 0; tick();
    n_cmp++;
    if ({alu_stall, rf_we, rf_rd_addr, pending[7]} !== {1'b0, 1'b1, 5'd7, 1'b0}) begin
      n_err++; $display("FAIL starve_drain: got stall=%b we=%b addr=%0d pend7=%b want 0/1/7/0",
                        alu_stall, rf_we, rf_rd_addr, pending[7]);
    end
    idle(2);
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 10; tick();
    issue_valid = 0;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'h0A0A_0001; tick();
    lsu_valid = 0;
    issue_valid = 1; issue_rd = 10; tick();
    issue_valid = 0;
    n_cmp++;
    if ({pending[10], rf_we, rf_rd_addr} !== {1'b1, 1'b1, 5'd10}) begin
      n_err++; $display("FAIL sb_set_wins: got pend10=%b we=%b addr=%0d want 1/1/10", pending[10], rf_we, rf_rd_addr);
    end
    lsu_valid = 1; lsu_data = 32'h0A0A_0002; tick();
    lsu_valid = 0; tick();
    n_cmp++;
    if (pending[10] !== 1'b0) begin
      n_err++; $display("FAIL sb_clear: got pend10=%b want 0", pending[10]);
    end
    issue_valid = 1; issue_rd = 0; tick();
    issue_valid = 0;
    n_cmp++;
    if (pending !== 32'd0) begin
      n_err++; $display("FAIL sb_x0: got pending=%h want 0", pending);
    end
    idle(2);
  endtask

  task automatic test_order_x0();
    issue_valid = 1; issue_rd = 3; tick();
    issue_valid = 0;
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'hAAAA_0003; tick();
    lsu_rd = 0; lsu_data = 32'hBBBB_0000; tick();
    lsu_rd = 3; lsu_data = 32'hCCCC_0003; tick();
    lsu_valid = 0;
    n_cmp++;
    if (rf_we !== 1'b0) begin
      n_err++; $display("FAIL ord_x0: got rf_we=%b want 0 for rd0 entry", rf_we);
    end
    tick();
    n_cmp++;
    if ({rf_we, rf_rd_addr, rf_rd_din, pending[3]} !== {1'b1, 5'd3, 32'hCCCC_0003, 1'b0}) begin
      n_err++; $display("FAIL ord_last: got we=%b addr=%0d din=%h pend3=%b want 1/3/cccc0003/0",
                        rf_we, rf_rd_addr, rf_rd_din, pending[3]);
    end
    idle(3);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_backpressure();
    test_starvation();
    test_scoreboard();
    test_order_x0();
    n_cmp++;
    if (alu_q.size() != 0 || lsu_q.size() != 0) begin
      n_err++; $display("FAIL final_queues: got %0d alu / %0d lsu outstanding want 0/0", alu_q.size(), lsu_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
